dualrail_tx: RTL and testbench

Clocked transmitter for the two-channel dual-rail, four-phase return-to-zero link consumed by the dual-rail completion-detect/handshake stage. It accepts single-rail word pairs through a valid/ready port, buffers up to two pairs, and encodes each pair onto true/false rail buses. It then sequences codeword → spacer phases against the receiver's asynchronous acknowledge. It sits at the synchronous-to-asynchronous boundary, feeding the first asynchronous pipeline stage of the accelerator datapath.

---
 rtl/dualrail_tx.sv | 179 +++++++++++++++++
 tb/tb_dualrail_tx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dualrail_tx.sv
// Dual-rail four-phase RZ transmitter: a 2-deep word-pair buffer feeding flop-driven true/false rails.
// Optional ack-timeout watchdog is enabled by defining DR_TIMEOUT_EN.
module dualrail_tx #(
    parameter int BIT0    = 8,
    parameter int BIT1    = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    input  logic [BIT0-1:0] in_data0,
    input  logic [BIT1-1:0] in_data1,
    output logic            in_ready,
    output logic [BIT0-1:0] dt_0,
    output logic [BIT0-1:0] df_0,
    output logic [BIT1-1:0] dt_1,
    output logic [BIT1-1:0] df_1,
    input  logic            ack_nxt,
    output logic            tx_busy,
    output logic            err
);

    localparam int W = BIT0 + BIT1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        SPACER = 2'd2
    } state_t;

    state_t       state;
    logic         ack_meta;
    logic         ack_s;
    logic [W-1:0] fifo_mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;
    logic [1:0]   count_next;
    logic         push;
    logic         pop;
    logic         launch;
    logic         to_spacer;
    logic         relaunch;
    logic [W-1:0] head_word;
    logic [W-1:0] next_word;

    assign push       = in_valid & in_ready;
    assign pop        = (state == SPACER) & ~ack_s;
    assign launch     = (state == IDLE) & (count != 2'd0) & ~ack_s;
    assign to_spacer  = (state == DATA) & ack_s;
    // Chaining straight into the next codeword only uses entries already stored before this edge.
    assign relaunch   = pop & (count == 2'd2);
    assign count_next = count + {1'b0, push} - {1'b0, pop};
    assign head_word  = fifo_mem[rd_ptr];
    assign next_word  = fifo_mem[~rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= ack_nxt;
            ack_s    <= ack_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {in_data1, in_data0};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count_next;
        end
    end

    // Rails, in_ready and tx_busy are all flops so every rail bit moves on one edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            dt_0     <= '0;
            df_0     <= '0;
            dt_1     <= '0;
            df_1     <= '0;
            in_ready <= 1'b0;
            tx_busy  <= 1'b0;
        end else begin
            in_ready <= (count_next != 2'd2);
            case (state)
                IDLE: begin
                    if (launch) begin
                        state        <= DATA;
                        {dt_1, dt_0} <= head_word;
                        {df_1, df_0} <= ~head_word;
                        tx_busy      <= 1'b1;
                    end else begin
                        tx_busy <= (count_next != 2'd0);
                    end
                end
                DATA: begin
                    tx_busy <= 1'b1;
                    if (to_spacer) begin
                        state <= SPACER;
                        dt_0  <= '0;
                        df_0  <= '0;
                        dt_1  <= '0;
                        df_1  <= '0;
                    end
                end
                SPACER: begin
                    if (relaunch) begin
                        state        <= DATA;
                        {dt_1, dt_0} <= next_word;
                        {df_1, df_0} <= ~next_word;
                        tx_busy      <= 1'b1;
                    end else if (pop) begin
                        state   <= IDLE;
                        tx_busy <= (count_next != 2'd0);
                    end else begin
                        tx_busy <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    dt_0    <= '0;
                    df_0    <= '0;
                    dt_1    <= '0;
                    df_1    <= '0;
                    tx_busy <= (count_next != 2'd0);
                end
            endcase
        end
    end

`ifdef DR_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] T_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] wait_cnt;
    logic          err_r;
    logic          entering;
    logic          waiting;

    assign entering = launch | to_spacer | relaunch;
    assign waiting  = ((state == DATA) & ~ack_s) | ((state == SPACER) & ack_s);
    assign err      = err_r;

    // Watchdog only flags a stuck handshake; the FSM keeps waiting and the rails are untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
            err_r    <= 1'b0;
        end else if (entering) begin
            wait_cnt <= '0;
        end else if (waiting && (wait_cnt != T_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == T_LAST) begin
                err_r <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dualrail_tx.sv
// Directed + randomized bench for dualrail_tx with a model receiver that decodes rails and drives ack.
// Build with DR_TIMEOUT_EN defined to exercise the ack-timeout flag (TIMEOUT overridden to 16).
module tb_dualrail_tx;

    localparam int BIT0 = 8;
    localparam int BIT1 = 16;

    logic            clk;
    logic            reset_n;
    logic            in_valid;
    logic [BIT0-1:0] in_data0;
    logic [BIT1-1:0] in_data1;
    logic            in_ready;
    logic [BIT0-1:0] dt_0;
    logic [BIT0-1:0] df_0;
    logic [BIT1-1:0] dt_1;
    logic [BIT1-1:0] df_1;
    logic            ack_nxt;
    logic            tx_busy;
    logic            err;

    logic            rx_en;
    logic            man_ack;
    logic            rx_ack;
    logic            rx_busy;
    logic            mon_en;
    logic            is_code;
    logic            is_spacer;
    logic [23:0]     exp_q[$];
    int              tests;
    int              fails;
    int              decoded;

    assign ack_nxt   = rx_en ? rx_ack : man_ack;
    assign is_spacer = ((dt_0 | df_0) == 8'h00) && ((dt_1 | df_1) == 16'h0000);
    assign is_code   = (&(dt_0 ^ df_0)) && (&(dt_1 ^ df_1));

    dualrail_tx #(
        .BIT0    (BIT0),
        .BIT1    (BIT1),
        .TIMEOUT (16)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_data0 (in_data0),
        .in_data1 (in_data1),
        .in_ready (in_ready),
        .dt_0     (dt_0),
        .df_0     (df_0),
        .dt_1     (dt_1),
        .df_1     (df_1),
        .ack_nxt  (ack_nxt),
        .tx_busy  (tx_busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Present a pair and hold it until the DUT takes it; the model queue records accepted pairs.
    task automatic applyStimulus(input logic [7:0] d0, input logic [15:0] d1, input int max_wait,
                                 output bit ok);
        int waited;
        waited = 0;
        ok = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data0 = d0;
        in_data1 = d1;
        while (!ok && waited < max_wait) begin
            if (in_ready) begin
                @(posedge clk);
                ok = 1'b1;
                exp_q.push_back({d1, d0});
            end else begin
                @(negedge clk);
                waited++;
            end
        end
        #1 in_valid = 1'b0;
        checkOutput("accept", 64'(ok), 64'd1);
    endtask

    task automatic drainAll(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !tx_busy && !rx_busy && !ack_nxt) done = 1'b1;
        end
        checkOutput("drain", 64'(done), 64'd1);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput("onehot", 64'(((dt_0 & df_0) != 8'h00) || ((dt_1 & df_1) != 16'h0000)), 64'd0);
            checkOutput("no_mixed", 64'(is_code || is_spacer), 64'd1);
        end
    end

    // Model receiver: decode a codeword, ack after a random delay and phase, release ack on spacer.
    initial begin
        rx_ack  = 1'b0;
        rx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rx_en) begin
                rx_ack = man_ack;
            end else if (!rx_ack && is_code) begin
                rx_busy = 1'b1;
                checkOutput("rx_expected_pair", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    checkOutput("rx_word", 64'({dt_1, dt_0}), 64'(exp_q.pop_front()));
                end
                decoded++;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                #($urandom_range(0, 9)) rx_ack = 1'b1;
                rx_busy = 1'b0;
            end else if (rx_ack && is_spacer) begin
                rx_busy = 1'b1;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                #($urandom_range(0, 9)) rx_ack = 1'b0;
                rx_busy = 1'b0;
            end
        end
    end

    initial begin
        bit          ok;
        int          d_start;
        logic [7:0]  r0;
        logic [15:0] r1;

        tests    = 0;
        fails    = 0;
        decoded  = 0;
        mon_en   = 1'b0;
        rx_en    = 1'b0;
        man_ack  = 1'b0;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data0 = '0;
        in_data1 = '0;

        // Reset state
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_rails", 64'({dt_1, df_1, dt_0, df_0}), 64'd0);
        checkOutput("rst_busy", 64'(tx_busy), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_rst", 64'(in_ready), 64'd1);

        // Single pair with a hand-driven ack
        applyStimulus(8'hA5, 16'h1234, 20, ok);
        exp_q.delete();
        @(negedge clk);
        checkOutput("t1_spacer_before_launch", 64'(is_spacer), 64'd1);
        checkOutput("t1_busy", 64'(tx_busy), 64'd1);
        @(negedge clk);
        checkOutput("t1_dt0", 64'(dt_0), 64'hA5);
        checkOutput("t1_df0", 64'(df_0), 64'h5A);
        checkOutput("t1_dt1", 64'(dt_1), 64'h1234);
        checkOutput("t1_df1", 64'(df_1), 64'hEDCB);
        repeat (2) @(negedge clk);
        man_ack = 1'b1;
        @(negedge clk);
        checkOutput("t1_hold_a", 64'(dt_0), 64'hA5);
        @(negedge clk);
        checkOutput("t1_hold_b", 64'(dt_0), 64'hA5);
        @(negedge clk);
        checkOutput("t1_spacer", 64'(is_spacer), 64'd1);
        man_ack = 1'b0;
        @(negedge clk);
        checkOutput("t1_busy_spacer_a", 64'(tx_busy), 64'd1);
        @(negedge clk);
        checkOutput("t1_busy_spacer_b", 64'(tx_busy), 64'd1);
        @(negedge clk);
        checkOutput("t1_idle_busy", 64'(tx_busy), 64'd0);
        checkOutput("t1_idle_rails", 64'(is_spacer), 64'd1);

        // Back-to-back pushes while ack is held high
        man_ack = 1'b1;
        repeat (3) @(negedge clk);
        applyStimulus(8'($urandom), 16'($urandom), 5, ok);
        applyStimulus(8'($urandom), 16'($urandom), 5, ok);
        checkOutput("t2_full_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("t2_hold_ready", 64'(in_ready), 64'd0);
            checkOutput("t2_hold_spacer", 64'(is_spacer), 64'd1);
        end
        rx_en = 1'b1;
        applyStimulus(8'($urandom), 16'($urandom), 300, ok);
        checkOutput("t2_third_after_pop", 64'(decoded >= 1), 64'd1);
        drainAll(400);
        checkOutput("t2_decoded", 64'(decoded), 64'd3);

        // 200 random pairs against the asynchronous model receiver
        d_start = decoded;
        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            r0 = 8'($urandom);
            r1 = 16'($urandom);
            applyStimulus(r0, r1, 400, ok);
        end
        drainAll(8000);
        checkOutput("t3_decoded", 64'(decoded - d_start), 64'd200);

        // Reset mid-DATA, then release with ack still high
        man_ack = 1'b0;
        @(negedge clk);
        rx_en = 1'b0;
        applyStimulus(8'h3C, 16'hBEEF, 20, ok);
        repeat (2) @(negedge clk);
        checkOutput("t4_in_data", 64'({dt_1, dt_0}), 64'h00BEEF3C);
        applyStimulus(8'h77, 16'h0F0F, 20, ok);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("t4_async_rails", 64'({dt_1, df_1, dt_0, df_0}), 64'd0);
        checkOutput("t4_async_busy", 64'(tx_busy), 64'd0);
        checkOutput("t4_async_err", 64'(err), 64'd0);
        exp_q.delete();
        man_ack = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("t4_ready", 64'(in_ready), 64'd1);
        checkOutput("t4_fifo_empty", 64'(tx_busy), 64'd0);
        d_start = decoded;
        applyStimulus(8'h5A, 16'hC3C3, 20, ok);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("t4_wait_ack_low", 64'(is_spacer), 64'd1);
            checkOutput("t4_busy_waiting", 64'(tx_busy), 64'd1);
        end
        rx_en = 1'b1;
        drainAll(200);
        checkOutput("t4_decoded", 64'(decoded - d_start), 64'd1);

        // Receiver never acks: watchdog behaviour
        man_ack = 1'b0;
        @(negedge clk);
        rx_en = 1'b0;
        applyStimulus(8'h81, 16'h4242, 20, ok);
        @(negedge clk);
        checkOutput("t5_not_yet", 64'(is_spacer), 64'd1);
        @(negedge clk);
        checkOutput("t5_data", 64'({dt_1, dt_0}), 64'h00424281);
`ifdef DR_TIMEOUT_EN
        repeat (15) @(negedge clk);
        checkOutput("t5_err_before", 64'(err), 64'd0);
        @(negedge clk);
        checkOutput("t5_err_rise", 64'(err), 64'd1);
        repeat (5) @(negedge clk);
        checkOutput("t5_err_sticky", 64'(err), 64'd1);
`else
        repeat (40) @(negedge clk);
        checkOutput("t5_err_tied", 64'(err), 64'd0);
`endif
        checkOutput("t5_rails_held", 64'({dt_1, dt_0}), 64'h00424281);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
